// File: rtl/song_seq.sv
// Melody sequencer: plays the note ROM at a fixed tempo and produces octave digits and a speaker square wave.
// Define SONG_SEQ_LOOP_EN to loop the song forever; otherwise the song ends in IDLE after the last entry.
module song_seq #(
    parameter int TICK_DIV = 250000,
    parameter int SONG_LEN = 32
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic       play,
    input  logic       stop,
    output logic [3:0] high,
    output logic [3:0] med,
    output logic [3:0] low,
    output logic       spk,
    output logic [4:0] step,
    output logic       busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [4:0]    STEP_LAST = 5'(SONG_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE} state_t;

    // Returns {octave, degree}; rests (octave 0 or degree 0) collapse to all zeros.
    function automatic logic [4:0] rom_note(input logic [4:0] idx);
        logic [7:0] e;
        case (idx)
            5'd0:  e = 8'h21;  5'd1:  e = 8'h25;  5'd2:  e = 8'h33;  5'd3:  e = 8'h00;
            5'd4:  e = 8'h16;  5'd5:  e = 8'h15;  5'd6:  e = 8'h23;  5'd7:  e = 8'h21;
            5'd8:  e = 8'h00;  5'd9:  e = 8'h25;  5'd10: e = 8'h26;  5'd11: e = 8'h25;
            5'd12: e = 8'h23;  5'd13: e = 8'h31;  5'd14: e = 8'h00;  5'd15: e = 8'h27;
            5'd16: e = 8'h26;  5'd17: e = 8'h25;  5'd18: e = 8'h23;  5'd19: e = 8'h22;
            5'd20: e = 8'h00;  5'd21: e = 8'h21;  5'd22: e = 8'h23;  5'd23: e = 8'h25;
            5'd24: e = 8'h31;  5'd25: e = 8'h32;  5'd26: e = 8'h31;  5'd27: e = 8'h00;
            5'd28: e = 8'h25;  5'd29: e = 8'h23;  5'd30: e = 8'h22;  default: e = 8'h21;
        endcase
        if (e[5:4] == 2'd0 || e[2:0] == 3'd0) return 5'd0;
        return {e[5:4], e[2:0]};
    endfunction

    state_t          r_state;
    logic [4:0]      r_step;
    logic [TW-1:0]   r_tick;
    logic [4:0]      r_note;
    logic [11:0]     r_tone;
    logic [3:0]      r_high, r_med, r_low;
    logic            r_spk, r_busy;

    logic [4:0]      w_note_nxt;
    logic [11:0]     w_base, w_half;
    logic            w_tone_on;

    always_comb begin
        case (r_state)
            ST_IDLE:  w_note_nxt = 5'd0;
            ST_PLAY:  w_note_nxt = rom_note(r_step);
            default:  w_note_nxt = r_note;
        endcase
    end

    always_comb begin
        case (r_note[2:0])
            3'd1:    w_base = 12'd1908;
            3'd2:    w_base = 12'd1701;
            3'd3:    w_base = 12'd1515;
            3'd4:    w_base = 12'd1433;
            3'd5:    w_base = 12'd1276;
            3'd6:    w_base = 12'd1136;
            default: w_base = 12'd1012;
        endcase
        case (r_note[4:3])
            2'd1:    w_half = w_base << 1;
            2'd3:    w_half = w_base >> 1;
            default: w_half = w_base;
        endcase
    end

    // A note change restarts the tone from a clean low phase.
    assign w_tone_on = (r_state == ST_PLAY) && (r_note != 5'd0) && (w_note_nxt == r_note);

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= 5'd0;
            r_tick  <= '0;
            r_note  <= 5'd0;
            r_tone  <= 12'd0;
            r_high  <= 4'd0;
            r_med   <= 4'd0;
            r_low   <= 4'd0;
            r_spk   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_note <= w_note_nxt;
            r_high <= (w_note_nxt[4:3] == 2'd3) ? {1'b0, w_note_nxt[2:0]} : 4'd0;
            r_med  <= (w_note_nxt[4:3] == 2'd2) ? {1'b0, w_note_nxt[2:0]} : 4'd0;
            r_low  <= (w_note_nxt[4:3] == 2'd1) ? {1'b0, w_note_nxt[2:0]} : 4'd0;

            if (!w_tone_on) begin
                r_tone <= 12'd0;
                r_spk  <= 1'b0;
            end else if (r_tone == w_half - 12'd1) begin
                r_tone <= 12'd0;
                r_spk  <= ~r_spk;
            end else begin
                r_tone <= r_tone + 12'd1;
            end

            if (stop) begin
                r_state <= ST_IDLE;
                r_step  <= 5'd0;
                r_tick  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (play) begin
                        r_state <= ST_PLAY;
                        r_step  <= 5'd0;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                    ST_PLAY: if (play) begin
                        r_state <= ST_PAUSE;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_step == STEP_LAST) begin
                            r_step <= 5'd0;
`ifndef SONG_SEQ_LOOP_EN
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_step <= r_step + 5'd1;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                    ST_PAUSE: if (play) r_state <= ST_PLAY;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign high = r_high;
    assign med  = r_med;
    assign low  = r_low;
    assign spk  = r_spk;
    assign step = r_step;
    assign busy = r_busy;
endmodule

// File: tb/tb_song_seq.sv
// Bench for song_seq: control behaviour on a fast-tempo instance, tone periods on a slow-tempo instance.
`timescale 1ns/1ps
module tb_song_seq;
  localparam int TD   = 10;
  localparam int TD_T = 5000;
  localparam int SL   = 5;
`ifdef SONG_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk_1mhz = 1'b0;
  always #500 clk_1mhz = ~clk_1mhz;

  logic       rst, play, stop;
  logic [3:0] high, med, low;
  logic       spk, busy;
  logic [4:0] step;
  logic       t_play, t_stop;
  logic [3:0] t_high, t_med, t_low;
  logic       t_spk, t_busy;
  logic [4:0] t_step;

  song_seq #(.TICK_DIV(TD), .SONG_LEN(SL)) dut (
    .clk_1mhz(clk_1mhz), .rst(rst), .play(play), .stop(stop),
    .high(high), .med(med), .low(low), .spk(spk), .step(step), .busy(busy));

  song_seq #(.TICK_DIV(TD_T), .SONG_LEN(SL)) dut_t (
    .clk_1mhz(clk_1mhz), .rst(rst), .play(t_play), .stop(t_stop),
    .high(t_high), .med(t_med), .low(t_low), .spk(t_spk), .step(t_step), .busy(t_busy));

  int compared = 0;
  int mismatched = 0;

  logic [7:0] rom_m [SL] = '{8'h21, 8'h25, 8'h33, 8'h00, 8'h16};
  int half_tab [7] = '{1908, 1701, 1515, 1433, 1276, 1136, 1012};

  // reference model: 0 idle, 1 play, 2 pause
  int m_st, m_step, m_tick;
  logic [3:0] m_hi, m_md, m_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] note_digits(input logic [7:0] e);
    logic [3:0] d;
    d = {1'b0, e[2:0]};
    if (d == 4'd0) return 12'd0;
    case (e[5:4])
      2'd1: return {8'h00, d};
      2'd2: return {4'h0, d, 4'h0};
      2'd3: return {d, 8'h00};
      default: return 12'd0;
    endcase
  endfunction

  function automatic int tone_half(input logic [7:0] e);
    int h;
    h = half_tab[e[2:0] - 1];
    if (e[5:4] == 2'd1) return h * 2;
    if (e[5:4] == 2'd3) return h / 2;
    return h;
  endfunction

  task automatic model_reset();
    m_st = 0; m_step = 0; m_tick = 0;
    m_hi = 0; m_md = 0; m_lo = 0;
  endtask

  task automatic model_clock(input bit p, input bit s);
    if (m_st == 0) {m_hi, m_md, m_lo} = 12'd0;
    else if (m_st == 1) {m_hi, m_md, m_lo} = note_digits(rom_m[m_step]);
    if (s) begin
      m_st = 0; m_step = 0; m_tick = 0;
    end else if (m_st == 0) begin
      if (p) begin m_st = 1; m_step = 0; m_tick = 0; end
    end else if (m_st == 2) begin
      if (p) m_st = 1;
    end else if (p) begin
      m_st = 2;
    end else if (m_tick < TD - 1) begin
      m_tick++;
    end else begin
      m_tick = 0;
      if (m_step < SL - 1) m_step++;
      else begin
        m_step = 0;
        if (!LOOP) m_st = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("step", 32'(step), 32'(m_step));
    chk("high", 32'(high), 32'(m_hi));
    chk("med",  32'(med),  32'(m_md));
    chk("low",  32'(low),  32'(m_lo));
    chk("spk",  32'(spk),  32'd0);
  endtask

  task automatic cyc(input bit p, input bit s);
    play = p; stop = s;
    @(posedge clk_1mhz); #1;
    play = 1'b0; stop = 1'b0;
    model_clock(p, s);
    check_all();
  endtask

  task automatic t_cycles(input int n);
    repeat (n) begin @(posedge clk_1mhz); #1; end
  endtask

  task automatic wait_toggle(output int n, input int bound);
    logic prev;
    prev = t_spk;
    n = 0;
    while (t_spk === prev && n < bound) begin
      @(posedge clk_1mhz); #1;
      n++;
    end
  endtask

  task automatic wait_t_step(input logic [4:0] target, input int bound);
    int n;
    n = 0;
    while (t_step !== target && n < bound) begin
      @(posedge clk_1mhz); #1;
      n++;
    end
    chk("tone_reach_step", 32'(t_step), 32'(target));
  endtask

  initial begin
    int n, viol;
    bit p, s;
    rst = 1'b1; play = 1'b0; stop = 1'b0; t_play = 1'b0; t_stop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_1mhz);
    #1;
    check_all();
    chk("reset_t_busy", 32'(t_busy), 32'd0);
    chk("reset_t_spk", 32'(t_spk), 32'd0);
    @(negedge clk_1mhz) rst = 1'b0;
    @(posedge clk_1mhz); #1;
    check_all();

    // play from idle
    cyc(1, 0);
    chk("play_busy_n1", 32'(busy), 32'd1);
    cyc(0, 0);
    chk("play_med_n2", 32'({high, med, low}), 32'h010);
    repeat (10) cyc(0, 0);
    chk("beat1_step", 32'(step), 32'd1);
    chk("beat1_med", 32'(med), 32'd5);

    // pause at tick 4 of step 1, then resume
    repeat (3) cyc(0, 0);
    cyc(1, 0);
    repeat (50) cyc(0, 0);
    chk("pause_step", 32'(step), 32'd1);
    chk("pause_med", 32'(med), 32'd5);
    chk("pause_busy", 32'(busy), 32'd1);
    cyc(1, 0);
    n = 0;
    while (step == 5'd1 && n < 20) begin cyc(0, 0); n++; end
    chk("resume_cycles", 32'(n), 32'd6);
    cyc(0, 0);
    chk("beat2_high_med", 32'({high, med}), 32'h30);

    // reset while playing at step 2
    rst = 1'b1; #1;
    model_reset();
    chk("rst_outputs", 32'({high, med, low, spk, busy}), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    @(negedge clk_1mhz) rst = 1'b0;
    repeat (6) cyc(0, 0);
    chk("rst_stays_idle", 32'(busy), 32'd0);

    // stop and play together during play
    cyc(1, 0);
    repeat (7) cyc(0, 0);
    cyc(1, 1);
    chk("stopplay_busy", 32'(busy), 32'd0);
    chk("stopplay_step", 32'(step), 32'd0);
    cyc(0, 0);
    chk("stopplay_digits", 32'({high, med, low}), 32'd0);

    // end of song
    cyc(1, 0);
    n = 0;
    while (step != 5'd4 && n < 100) begin cyc(0, 0); n++; end
    chk("song_reach4", 32'(step), 32'd4);
    n = 0;
    while (step == 5'd4 && n < 20) begin cyc(0, 0); n++; end
    cyc(0, 0);
    if (LOOP) begin
      chk("end_loop_step", 32'(step), 32'd0);
      chk("end_loop_med", 32'({high, med, low}), 32'h010);
      chk("end_loop_busy", 32'(busy), 32'd1);
    end else begin
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_digits", 32'({high, med, low}), 32'd0);
    end
    cyc(0, 1);
    cyc(0, 0);

    // random play/stop pulses against the model
    repeat (400) begin
      p = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 47) == 0);
      cyc(p, s);
    end
    cyc(0, 1);
    cyc(0, 0);

    // tone periods on the slow-tempo instance
    t_play = 1'b1;
    @(posedge clk_1mhz); #1;
    t_play = 1'b0;
    wait_toggle(n, 3000);
    wait_toggle(n, 3000);
    chk("tone_step0_half", 32'(n), 32'(tone_half(rom_m[0])));
    wait_t_step(5'd2, 12000);
    wait_toggle(n, 3000);
    wait_toggle(n, 3000);
    chk("tone_step2_half", 32'(n), 32'(tone_half(rom_m[2])));
    chk("tone_step2_high", 32'(t_high), 32'd3);
    wait_t_step(5'd3, 6000);
    t_cycles(2);
    viol = 0;
    repeat (2500) begin
      if (t_spk !== 1'b0 || {t_high, t_med, t_low} !== 12'd0) viol++;
      @(posedge clk_1mhz); #1;
    end
    chk("rest_quiet", 32'(viol), 32'd0);
    wait_t_step(5'd4, 6000);
    wait_toggle(n, 5000);
    wait_toggle(n, 5000);
    chk("tone_step4_half", 32'(n), 32'(tone_half(rom_m[4])));
    chk("tone_step4_low", 32'(t_low), 32'd6);
    t_stop = 1'b1;
    @(posedge clk_1mhz); #1;
    t_stop = 1'b0;
    t_cycles(2);
    chk("tone_stop_spk", 32'({t_spk, t_busy}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
